// File: rtl/noise_burst_ctrl.sv
// noise_burst_ctrl: gates a 12-bit Fibonacci LFSR into programmable bursts
// separated by silent gaps, with start/stop control and a latched config.
module noise_burst_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned REP_W        = 8,
  parameter logic [11:0] DEFAULT_SEED = 12'h001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [11:0]      cfg_seed_i,
  input  logic [CNT_W-1:0] cfg_burst_len_i,
  input  logic [CNT_W-1:0] cfg_gap_len_i,
  input  logic [REP_W-1:0] cfg_repeat_i,
  output logic             noise_q_o,
  output logic             noise_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [REP_W-1:0] burst_idx_o
);

  localparam int unsigned LFSR_W = 12;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [LFSR_W-1:0] lfsr_q,    lfsr_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [REP_W-1:0]  idx_q,     idx_d;
  logic [LFSR_W-1:0] seed_q,    seed_d;
  logic [CNT_W-1:0]  blen_q,    blen_d;
  logic [CNT_W-1:0]  glen_q,    glen_d;
  logic [REP_W-1:0]  rep_q,     rep_d;
  logic              cfg_err_q, cfg_err_d;

  logic [LFSR_W-1:0] lfsr_next;
  logic [REP_W-1:0]  idx_inc;

  // LFSR step and incremented burst index used by the burst-end decision
  always_comb begin
    lfsr_next = {lfsr_q[10:0], lfsr_q[0] ^ lfsr_q[3] ^ lfsr_q[4] ^ lfsr_q[11]};
    idx_inc   = REP_W'(idx_q + REP_W'(1));
  end

  // Next-state and datapath update; stop always wins over burst/gap completion
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    blen_d    = blen_q;
    glen_d    = glen_q;
    rep_d     = rep_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          if (cfg_burst_len_i != '0) begin
            seed_d  = cfg_seed_i;
            blen_d  = cfg_burst_len_i;
            glen_d  = cfg_gap_len_i;
            rep_d   = cfg_repeat_i;
            state_d = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d  = (seed_q == '0) ? DEFAULT_SEED : seed_q;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d = lfsr_next;
          if (cnt_q == CNT_W'(blen_q - CNT_W'(1))) begin
            cnt_d = '0;
            idx_d = idx_inc;
            if (rep_q != '0 && idx_inc == rep_q) begin
              state_d = S_DONE;
            end else if (glen_q == '0) begin
              state_d = S_BURST;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
        end
      end
      S_GAP: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(glen_q - CNT_W'(1))) begin
          cnt_d   = '0;
          state_d = S_BURST;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      lfsr_q    <= DEFAULT_SEED;
      cnt_q     <= '0;
      idx_q     <= '0;
      seed_q    <= '0;
      blen_q    <= '0;
      glen_q    <= '0;
      rep_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      blen_q    <= blen_d;
      glen_q    <= glen_d;
      rep_q     <= rep_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Moore output decode from registered state
  always_comb begin
    noise_valid_o = (state_q == S_BURST);
    noise_q_o     = (state_q == S_BURST) & lfsr_q[0];
    busy_o        = (state_q == S_LOAD) || (state_q == S_BURST) || (state_q == S_GAP);
    done_o        = (state_q == S_DONE);
    cfg_err_o     = cfg_err_q;
    burst_idx_o   = idx_q;
  end

endmodule
